// File: rtl/sha256_digest_unloader.sv
// Captures SHA-256 digests on the core's completion pulse and streams them MSW-first as words over valid/ready.
// Active + pending entries absorb back-to-back digests; a digest arriving with both full is dropped and counted.
module sha256_digest_unloader #(
    parameter int DIGEST_BITS = 256,
    parameter int WORD_BITS   = 32,
    parameter int CNT_BITS    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [DIGEST_BITS-1:0] i_digest_in,
    input  logic                   i_digest_valid,
    output logic [WORD_BITS-1:0]   o_word_out,
    output logic                   o_word_valid,
    input  logic                   i_word_ready,
    output logic                   o_word_last,
    output logic                   o_busy,
    output logic                   o_overflow,
    output logic [CNT_BITS-1:0]    o_drop_count
);

    localparam int NWORDS   = DIGEST_BITS / WORD_BITS;
    localparam int IDX_BITS = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NWORDS - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                 r_state;
    logic [DIGEST_BITS-1:0] r_active;
    logic [DIGEST_BITS-1:0] r_pending;
    logic                   r_pend_full;
    logic [IDX_BITS-1:0]    r_idx;
    logic                   r_overflow;
    logic [CNT_BITS-1:0]    r_drop_count;

    state_t                 w_state_nxt;
    logic [DIGEST_BITS-1:0] w_active_nxt;
    logic [DIGEST_BITS-1:0] w_pending_nxt;
    logic                   w_pend_full_nxt;
    logic [IDX_BITS-1:0]    w_idx_nxt;
    logic                   w_overflow_nxt;
    logic [CNT_BITS-1:0]    w_drop_nxt;

    logic [WORD_BITS-1:0]   w_words [NWORDS];
    logic                   w_xfer;
    logic                   w_last_xfer;

    // Word 0 is the most significant slice (H0).
    for (genvar g = 0; g < NWORDS; g++) begin : g_words
        assign w_words[g] = r_active[DIGEST_BITS-1-g*WORD_BITS -: WORD_BITS];
    end

    // All outputs come from registers only; i_word_ready reaches next-state logic alone.
    assign o_word_valid = (r_state == S_SEND);
    assign o_word_out   = w_words[r_idx];
    assign o_word_last  = o_word_valid && (r_idx == LAST_IDX);
    assign o_busy       = (r_state == S_SEND) || r_pend_full;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;

    assign w_xfer      = o_word_valid && i_word_ready;
    assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);

    always_comb begin
        w_state_nxt     = r_state;
        w_active_nxt    = r_active;
        w_pending_nxt   = r_pending;
        w_pend_full_nxt = r_pend_full;
        w_idx_nxt       = r_idx;
        w_overflow_nxt  = r_overflow;
        w_drop_nxt      = r_drop_count;
        case (r_state)
            S_IDLE: begin
                if (i_digest_valid) begin
                    w_active_nxt = i_digest_in;
                    w_idx_nxt    = '0;
                    w_state_nxt  = S_SEND;
                end
            end
            S_SEND: begin
                if (w_last_xfer) begin
                    // Last word leaves: refill active without a bubble if anything is waiting.
                    w_idx_nxt = '0;
                    if (r_pend_full) begin
                        w_active_nxt = r_pending;
                        if (i_digest_valid) begin
                            w_pending_nxt = i_digest_in;
                        end else begin
                            w_pend_full_nxt = 1'b0;
                        end
                    end else if (i_digest_valid) begin
                        w_active_nxt = i_digest_in;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_idx_nxt = r_idx + IDX_BITS'(1);
                    end
                    if (i_digest_valid) begin
                        if (!r_pend_full) begin
                            w_pending_nxt   = i_digest_in;
                            w_pend_full_nxt = 1'b1;
                        end else begin
                            w_overflow_nxt = 1'b1;
                            if (r_drop_count != '1) begin
                                w_drop_nxt = r_drop_count + CNT_BITS'(1);
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_full  <= 1'b0;
            r_idx        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_active     <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_pend_full  <= w_pend_full_nxt;
            r_idx        <= w_idx_nxt;
            r_overflow   <= w_overflow_nxt;
            r_drop_count <= w_drop_nxt;
        end
    end

endmodule

// File: tb/tb_sha256_digest_unloader.sv
// Directed bench for sha256_digest_unloader: table of digests with hand-written word lists, plus corner-case sequences.
module tb_sha256_digest_unloader;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] digest_in;
    logic         digest_valid;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic         busy;
    logic         overflow;
    logic [7:0]   drop_count;

    sha256_digest_unloader #(.DIGEST_BITS(256), .WORD_BITS(32), .CNT_BITS(8)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_digest_in    (digest_in),
        .i_digest_valid (digest_valid),
        .o_word_out     (word_out),
        .o_word_valid   (word_valid),
        .i_word_ready   (word_ready),
        .o_word_last    (word_last),
        .o_busy         (busy),
        .o_overflow     (overflow),
        .o_drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0]        dig;
        logic [0:7][31:0]    w;
    } vec_t;

    vec_t vt [4];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_expect(input logic [0:7][31:0] w, input string tag);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s valid w%0d", tag, k), {31'd0, word_valid}, 32'd1);
            chk($sformatf("%s word w%0d", tag, k), word_out, w[k]);
            chk($sformatf("%s last w%0d", tag, k), {31'd0, word_last}, (k == 7) ? 32'd1 : 32'd0);
            step();
        end
    endtask

    task automatic pulse(input logic [255:0] d);
        digest_in    = d;
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [31:0] prev_word;
        logic        prev_stall;
        int          got;

        vt[0].dig = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        vt[0].w   = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                     32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        vt[1].dig = {8{32'h11111111}};
        vt[1].w   = {8{32'h11111111}};
        vt[2].dig = {8{32'h22222222}};
        vt[2].w   = {8{32'h22222222}};
        vt[3].dig = 256'h01234567_89abcdef_deadbeef_cafef00d_00000000_ffffffff_a5a5a5a5_5a5a5a5a;
        vt[3].w   = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d,
                     32'h00000000, 32'hffffffff, 32'ha5a5a5a5, 32'h5a5a5a5a};

        reset        = 1'b1;
        digest_in    = '0;
        digest_valid = 1'b0;
        word_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst word_out", word_out, 32'd0);
        chk("rst word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst word_last", {31'd0, word_last}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst overflow", {31'd0, overflow}, 32'd0);
        chk("rst drop_count", {24'd0, drop_count}, 32'd0);

        // Single digests at full throughput, one per table entry.
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse(vt[i].dig);
            stream_expect(vt[i].w, $sformatf("single%0d", i));
            chk($sformatf("single%0d busy after", i), {31'd0, busy}, 32'd0);
            chk($sformatf("single%0d valid after", i), {31'd0, word_valid}, 32'd0);
        end

        // Backpressure with ready pattern 1,0,0,1 repeating.
        pulse(vt[0].dig);
        got        = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        for (int c = 0; c < 64 && got < 8; c++) begin
            word_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (prev_stall) begin
                chk($sformatf("bp valid held c%0d", c), {31'd0, word_valid}, 32'd1);
                chk($sformatf("bp word held c%0d", c), word_out, prev_word);
            end
            if (word_valid && word_ready) begin
                chk($sformatf("bp word %0d", got), word_out, vt[0].w[got]);
                chk($sformatf("bp last %0d", got), {31'd0, word_last}, (got == 7) ? 32'd1 : 32'd0);
                got++;
            end
            prev_stall = word_valid && !word_ready;
            prev_word  = word_out;
            step();
        end
        chk("bp word count", got, 32'd8);
        chk("bp no duplicate", {31'd0, word_valid}, 32'd0);

        // Back-to-back: B arrives two cycles after A; 16 valid cycles, no bubble.
        word_ready = 1'b1;
        pulse(vt[0].dig);
        for (int c = 1; c <= 16; c++) begin
            digest_in    = vt[1].dig;
            digest_valid = (c == 2);
            chk($sformatf("b2b valid c%0d", c), {31'd0, word_valid}, 32'd1);
            chk($sformatf("b2b word c%0d", c), word_out, (c <= 8) ? vt[0].w[c-1] : vt[1].w[c-9]);
            chk($sformatf("b2b last c%0d", c), {31'd0, word_last}, (c == 8 || c == 16) ? 32'd1 : 32'd0);
            step();
        end
        digest_valid = 1'b0;
        chk("b2b idle after", {31'd0, word_valid}, 32'd0);

        // Overflow: third digest dropped, A then B streamed.
        word_ready = 1'b0;
        pulse(vt[0].dig);
        pulse(vt[1].dig);
        pulse(vt[2].dig);
        chk("ovf overflow", {31'd0, overflow}, 32'd1);
        chk("ovf drop_count", {24'd0, drop_count}, 32'd1);
        chk("ovf busy", {31'd0, busy}, 32'd1);
        chk("ovf word held", word_out, vt[0].w[0]);
        word_ready = 1'b1;
        stream_expect(vt[0].w, "ovfA");
        stream_expect(vt[1].w, "ovfB");
        chk("ovf C not sent", {31'd0, word_valid}, 32'd0);
        chk("ovf sticky", {31'd0, overflow}, 32'd1);

        // Saturation of the drop counter.
        word_ready = 1'b0;
        pulse(vt[0].dig);
        pulse(vt[1].dig);
        digest_in    = vt[2].dig;
        digest_valid = 1'b1;
        for (int i = 0; i < 253; i++) step();
        chk("sat drop 254", {24'd0, drop_count}, 32'hFE);
        step();
        chk("sat drop 255", {24'd0, drop_count}, 32'hFF);
        for (int i = 0; i < 3; i++) step();
        digest_valid = 1'b0;
        chk("sat drop holds", {24'd0, drop_count}, 32'hFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sat cleared", {24'd0, drop_count}, 32'd0);

        // Simultaneous pulse and last-word transfer with pending empty.
        word_ready = 1'b1;
        pulse(vt[0].dig);
        for (int k = 0; k < 7; k++) step();
        chk("simE last", {31'd0, word_last}, 32'd1);
        chk("simE word7", word_out, vt[0].w[7]);
        pulse(vt[1].dig);
        chk("simE no bubble", {31'd0, word_valid}, 32'd1);
        stream_expect(vt[1].w, "simE_B");
        chk("simE no drop", {24'd0, drop_count}, 32'd0);

        // Simultaneous pulse and last-word transfer with pending full.
        word_ready = 1'b0;
        pulse(vt[0].dig);
        pulse(vt[1].dig);
        word_ready = 1'b1;
        for (int k = 0; k < 7; k++) step();
        chk("simF last", {31'd0, word_last}, 32'd1);
        pulse(vt[2].dig);
        stream_expect(vt[1].w, "simF_B");
        stream_expect(vt[2].w, "simF_C");
        chk("simF no drop", {24'd0, drop_count}, 32'd0);
        chk("simF no overflow", {31'd0, overflow}, 32'd0);
        chk("simF idle", {31'd0, busy}, 32'd0);

        // Reset mid-stream with B pending and a drop recorded.
        word_ready = 1'b0;
        pulse(vt[0].dig);
        pulse(vt[1].dig);
        pulse(vt[2].dig);
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("rms pre word4", word_out, vt[0].w[4]);
        chk("rms pre overflow", {31'd0, overflow}, 32'd1);
        reset        = 1'b1;
        digest_in    = vt[3].dig;
        digest_valid = 1'b1;
        step();
        reset        = 1'b0;
        digest_valid = 1'b0;
        chk("rms valid", {31'd0, word_valid}, 32'd0);
        chk("rms busy", {31'd0, busy}, 32'd0);
        chk("rms overflow", {31'd0, overflow}, 32'd0);
        chk("rms drop_count", {24'd0, drop_count}, 32'd0);
        chk("rms word_out", word_out, 32'd0);
        step();
        chk("rms pulse ignored", {31'd0, word_valid}, 32'd0);
        pulse(vt[3].dig);
        stream_expect(vt[3].w, "rmsD");
        chk("rms final idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha256_digest_unloader.md
Name: sha256_digest_unloader

Overview:
Downstream of the pipelined SHA-256 core: captures the 256-bit digest when the core's completion pulse fires. Streams it out as eight 32-bit words over a valid/ready interface.
Two-entry buffering (active + pending) absorbs back-to-back digests while the consumer applies backpressure. Digests that arrive with both entries full are dropped and counted.

Parameters:
DIGEST_BITS, 256, digest width captured per pulse
WORD_BITS, 32, output word width; DIGEST_BITS must be an integer multiple of it
CNT_BITS, 8, width of the saturating drop counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
digest_in  input  DIGEST_BITS  digest from compression stage (H_out)
digest_valid  input  1  single-cycle pulse: digest_in is final this cycle
word_out  output  WORD_BITS  current output word
word_valid  output  1  word_out holds a valid word
word_ready  input  1  consumer accepts word_out when high with word_valid
word_last  output  1  high with the final word (index 7) of a digest
busy  output  1  high while any digest entry is occupied
overflow  output  1  sticky: at least one digest was dropped since reset
drop_count  output  CNT_BITS  number of dropped digests, saturates at all-ones

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: word_out=0, word_valid=0, word_last=0, busy=0, overflow=0, drop_count=0; both entries empty; word index=0.
- Handshake: a transfer occurs in a cycle where word_valid && word_ready.
  - While word_valid=1 && word_ready=0, word_out and word_last hold stable.
  - word_valid never deasserts without a transfer.
- Word order: MSW first. Word k = active[DIGEST_BITS-1-k*WORD_BITS -: WORD_BITS], so k=0 is H0 (bits 255:224) and k=7 is H7 (bits 31:0).
- FSM states:
  - IDLE: active empty, word_valid=0.
  - SEND: active full, word_valid=1, index 0..7.
- Capture latency: digest_valid in cycle N while IDLE -> word_valid=1 with word 0 in cycle N+1.
- Index: increments on each transfer. word_last = (index==7) && word_valid.
- Transfer of the last word, by pending state:
  - Pending full: pending moves to active, index=0, state stays SEND. word_valid remains 1 next cycle (no bubble).
  - Pending empty and no digest_valid this cycle: go to IDLE.
- digest_valid while SEND:
  - Pending empty: digest stored in pending.
  - Pending full: digest dropped, overflow<=1, drop_count<=drop_count+1 (saturating).
- Simultaneous events (digest_valid in the same cycle as the last-word transfer):
  - Pending empty: the new digest loads directly into active, index=0, no bubble.
  - Pending full: pending moves to active, the new digest loads into pending, no drop.
- digest_valid held high for multiple cycles is treated as one capture per cycle; the core never does this.
- busy = active full || pending full.
- Reset mid-stream: the in-flight and pending digests are discarded. Outputs return to reset values next cycle. A digest_valid in the reset cycle is ignored.
- No combinational path from word_ready to word_valid or word_out. word_ready may feed only next-state logic.

Test Plan:
1. Single digest, word_ready=1: pulse with digest_in=ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad -> cycles N+1..N+8 emit ba7816bf, 8f01cfea, …, f20015ad. word_last only on f20015ad; busy falls at N+9.
2. Backpressure: same digest, word_ready toggling 1,0,0,1,… -> word_out is constant across each stall. All 8 words arrive exactly once, in order. Nothing is lost or duplicated.
3. Back-to-back: pulse digest A (abc digest above), pulse digest B = all 32'h11111111 words two cycles later, word_ready=1 -> 16 consecutive valid cycles with no bubble. word_last is high on cycles 8 and 16.
4. Overflow: word_ready=0, three pulses (A, B, C=32'h22222222 words) -> overflow=1, drop_count=1. Releasing word_ready streams A then B only. After 256 further drops, drop_count stays 8'hFF.
5. Simultaneous: pending empty, pulse B in the same cycle as A's word 7 transfer -> B word 0 (32'h11111111) is valid in the next cycle, no bubble.
6. Reset mid-stream: assert reset after word 3 of A with B pending -> next cycle word_valid=0, busy=0, overflow=0, drop_count=0. A new pulse streams correctly from word 0.
